// File: rtl/multicycle_fsm.sv
// Multicycle RISC-V control unit: sequences fetch, decode, execute, memory and
// writeback states and waits on a shared memory that may take several cycles.
module multicycle_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [3:0] ALUControl,
   output logic       Illegal,
   output logic [3:0] state
);

   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMREAD  = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWRITE = 4'd5;
   localparam logic [3:0] EXECUTER = 4'd6;
   localparam logic [3:0] EXECUTEI = 4'd7;
   localparam logic [3:0] ALUWB    = 4'd8;
   localparam logic [3:0] BRANCH   = 4'd9;
   localparam logic [3:0] JAL      = 4'd10;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic [3:0] state_next;

   function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic op5, input logic f7);
      logic [3:0] r;
      case (f3)
         3'b000:  r = (op5 & f7) ? 4'b0001 : 4'b0000;
         3'b001:  r = 4'b0110;
         3'b010:  r = 4'b0101;
         3'b100:  r = 4'b0100;
         3'b101:  r = f7 ? 4'b1000 : 4'b0111;
         3'b110:  r = 4'b0011;
         3'b111:  r = 4'b0010;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH:    state_next = MemReady ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXECUTER;
               OP_I:         state_next = EXECUTEI;
               OP_BR:        state_next = BRANCH;
               OP_JAL:       state_next = JAL;
               default:      state_next = FETCH;
            endcase
         end
         MEMADR:   state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  state_next = MemReady ? MEMWB : MEMREAD;
         MEMWB:    state_next = FETCH;
         MEMWRITE: state_next = MemReady ? FETCH : MEMWRITE;
         EXECUTER: state_next = ALUWB;
         EXECUTEI: state_next = ALUWB;
         ALUWB:    state_next = FETCH;
         BRANCH:   state_next = FETCH;
         JAL:      state_next = ALUWB;
         default:  state_next = FETCH;
      endcase
   end

   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = 4'b0000;
      Illegal    = 1'b0;
      case (op)
         OP_SW:   ImmSrc = 3'b001;
         OP_BR:   ImmSrc = 3'b010;
         OP_JAL:  ImmSrc = 3'b011;
         default: ImmSrc = 3'b000;
      endcase
      case (state)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            Illegal = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL});
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         MEMREAD:  AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         EXECUTER: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_dec(funct3, op[5], funct7b5);
         end
         EXECUTEI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_dec(funct3, op[5], funct7b5);
         end
         ALUWB:    RegWrite = 1'b1;
         BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = 4'b0001;
            PCWrite    = (funct3 == 3'b000) ? Zero : (funct3 == 3'b001) ? ~Zero : 1'b0;
         end
         JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
         end
         default: ;
      endcase
      // Write strobes must be quiet for the whole reset interval, even in FETCH with MemReady high.
      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         Illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_fsm.sv
// Scoreboard bench for multicycle_fsm: directed instruction sequences push the
// expected per-cycle control outputs; a negedge monitor pops and compares.
module tb_multicycle_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc;
   logic [3:0] ALUControl, state;

   multicycle_fsm dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .Illegal(Illegal), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic [4:0] we;   // {PCWrite, IRWrite, RegWrite, MemWrite, Illegal}
      logic       adr;
      logic [1:0] rs;
      logic [1:0] a;
      logic [1:0] b;
      logic [3:0] alu;
      logic [2:0] imm;
   } exp_t;

   localparam logic [4:0] W0  = 5'b00000;
   localparam logic [4:0] WPI = 5'b11000;
   localparam logic [4:0] WP  = 5'b10000;
   localparam logic [4:0] WR  = 5'b00100;
   localparam logic [4:0] WM  = 5'b00010;
   localparam logic [4:0] WI  = 5'b00001;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc_no = 0;
   logic [2:0] cur_imm;

   always @(negedge clk) begin
      exp_t e, g;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         g = '{state, {PCWrite, IRWrite, RegWrite, MemWrite, Illegal}, AdrSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc};
         n_chk++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL cycle%0d got st=%0d we=%b adr=%b rs=%b a=%b b=%b alu=%b imm=%b required st=%0d we=%b adr=%b rs=%b a=%b b=%b alu=%b imm=%b",
                     cyc_no, g.st, g.we, g.adr, g.rs, g.a, g.b, g.alu, g.imm,
                     e.st, e.we, e.adr, e.rs, e.a, e.b, e.alu, e.imm);
         end
      end
   end

   task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [2:0] imm);
      op = o; funct3 = f3; funct7b5 = f7; cur_imm = imm;
   endtask

   task automatic cyc(input logic r, input logic mr, input logic z, input logic [3:0] st,
                      input logic [4:0] we, input logic adr, input logic [1:0] rs,
                      input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu);
      reset = r; MemReady = mr; Zero = z;
      sb.push_back('{st, we, adr, rs, a, b, alu, cur_imm});
      @(posedge clk); #1;
      cyc_no++;
   endtask

   task automatic fetch(input logic mr);
      cyc(1'b0, mr, 1'b0, 4'd0, mr ? WPI : W0, 1'b0, 2'b10, 2'b00, 2'b10, 4'h0);
   endtask

   task automatic decode(input logic [4:0] we);
      cyc(1'b0, 1'b1, 1'b0, 4'd1, we, 1'b0, 2'b00, 2'b01, 2'b01, 4'h0);
   endtask

   task automatic aluwb();
      cyc(1'b0, 1'b1, 1'b0, 4'd8, WR, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0);
   endtask

   initial begin
      reset = 1'b1; MemReady = 1'b1; Zero = 1'b0;
      instr(7'b0110011, 3'b000, 1'b0, 3'b000);
      @(posedge clk); #1;

      // reset held with MemReady high: FETCH, no strobes
      cyc(1'b1, 1'b1, 1'b0, 4'd0, W0, 1'b0, 2'b10, 2'b00, 2'b10, 4'h0);
      cyc(1'b1, 1'b1, 1'b0, 4'd0, W0, 1'b0, 2'b10, 2'b00, 2'b10, 4'h0);

      // add: 0,1,6,8
      fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b0, 4'd6, W0, 1'b0, 2'b00, 2'b10, 2'b00, 4'b0000);
      aluwb();

      // sub (R-type, funct7b5=1)
      instr(7'b0110011, 3'b000, 1'b1, 3'b000);
      fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b0, 4'd6, W0, 1'b0, 2'b00, 2'b10, 2'b00, 4'b0001);
      aluwb();

      // lw with two wait cycles in MEMREAD: 0,1,2,3,3,3,4
      instr(7'b0000011, 3'b010, 1'b0, 3'b000);
      fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b0, 4'd2, W0, 1'b0, 2'b00, 2'b10, 2'b01, 4'h0);
      cyc(1'b0, 1'b0, 1'b0, 4'd3, W0, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0);
      cyc(1'b0, 1'b0, 1'b0, 4'd3, W0, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0);
      cyc(1'b0, 1'b1, 1'b0, 4'd3, W0, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0);
      cyc(1'b0, 1'b1, 1'b0, 4'd4, WR, 1'b0, 2'b01, 2'b00, 2'b00, 4'h0);

      // sw with a FETCH stall and one MEMWRITE wait
      instr(7'b0100011, 3'b010, 1'b0, 3'b001);
      fetch(1'b0); fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b0, 4'd2, W0, 1'b0, 2'b00, 2'b10, 2'b01, 4'h0);
      cyc(1'b0, 1'b0, 1'b0, 4'd5, WM, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0);
      cyc(1'b0, 1'b1, 1'b0, 4'd5, WM, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0);

      // beq taken, beq not taken, bne with Zero=0 taken
      instr(7'b1100011, 3'b000, 1'b0, 3'b010);
      fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b1, 4'd9, WP, 1'b0, 2'b00, 2'b10, 2'b00, 4'b0001);
      fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b0, 4'd9, W0, 1'b0, 2'b00, 2'b10, 2'b00, 4'b0001);
      instr(7'b1100011, 3'b001, 1'b0, 3'b010);
      fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b0, 4'd9, WP, 1'b0, 2'b00, 2'b10, 2'b00, 4'b0001);

      // jal: 0,1,10,8
      instr(7'b1101111, 3'b000, 1'b0, 3'b011);
      fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b0, 4'd10, WP, 1'b0, 2'b00, 2'b01, 2'b10, 4'h0);
      aluwb();

      // lui is unsupported: Illegal pulse in DECODE, then straight back to FETCH
      instr(7'b0110111, 3'b000, 1'b0, 3'b000);
      fetch(1'b1); decode(WI);

      // srai -> sra; addi with funct7b5 set stays add; ori
      instr(7'b0010011, 3'b101, 1'b1, 3'b000);
      fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b0, 4'd7, W0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b1000);
      aluwb();
      instr(7'b0010011, 3'b000, 1'b1, 3'b000);
      fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b0, 4'd7, W0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0000);
      aluwb();
      instr(7'b0010011, 3'b110, 1'b0, 3'b000);
      fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b0, 4'd7, W0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0011);
      aluwb();

      // reset raised mid-cycle during a stalled MEMWRITE: FETCH before the next edge
      instr(7'b0100011, 3'b010, 1'b0, 3'b001);
      fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b0, 4'd2, W0, 1'b0, 2'b00, 2'b10, 2'b01, 4'h0);
      cyc(1'b0, 1'b0, 1'b0, 4'd5, WM, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, W0, 1'b0, 2'b10, 2'b00, 2'b10, 4'h0);
      // first fetch after release
      fetch(1'b1); decode(W0);
      cyc(1'b0, 1'b1, 1'b0, 4'd2, W0, 1'b0, 2'b00, 2'b10, 2'b01, 4'h0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain got %0d pending entries required 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 SHALL have one clock and one reset: the clock is clk and the reset is reset; reset is asynchronous and active-high.
REQ-002 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  shared memory completes access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
- ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=const 4
- ImmSrc  out  3  000=I, 001=S, 010=B, 011=J
- ALUControl  out  4  ALU operation select
- Illegal  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug/verification

Function
REQ-003 SHALL implement the state register with encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10; encodings 11-15 SHALL go to FETCH on the next edge.
REQ-004 SHALL drive every output to 0 except where a state below sets it; ImmSrc SHALL be decoded from op in every state: sw→001, branch→010, jal→011, otherwise 000.
REQ-005 In FETCH, SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU add, ResultSrc=10; SHALL assert IRWrite=PCWrite=1 only when MemReady=1; SHALL hold in FETCH while MemReady=0, and go to DECODE when MemReady=1.
REQ-006 In DECODE, SHALL drive ALUSrcA=01, ALUSrcB=01, ALU add (branch target into ALUOut). Next state by op:
- 0000011/0100011 → MEMADR
- 0110011 → EXECUTER
- 0010011 → EXECUTEI
- 1100011 → BRANCH
- 1101111 → JAL
- any other op → FETCH, with Illegal=1 for that cycle
REQ-007 In MEMADR, SHALL drive ALUSrcA=10, ALUSrcB=01, add; next state MEMREAD if op=0000011, else MEMWRITE.
REQ-008 In MEMREAD, SHALL drive AdrSrc=1, ResultSrc=00; SHALL hold until MemReady=1, then go to MEMWB.
REQ-009 In MEMWB, SHALL drive ResultSrc=01, RegWrite=1; next state FETCH.
REQ-010 In MEMWRITE, SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle in the state; SHALL hold until MemReady=1, then go to FETCH.
REQ-011 In EXECUTER (ALUSrcA=10, ALUSrcB=00) and EXECUTEI (ALUSrcA=10, ALUSrcB=01), SHALL use funct decode (REQ-014); next state ALUWB.
REQ-012 In ALUWB, SHALL drive ResultSrc=00, RegWrite=1; next state FETCH.
REQ-013 In BRANCH, SHALL drive ALUSrcA=10, ALUSrcB=00, subtract, ResultSrc=00; PCWrite SHALL be Zero for funct3=000, ~Zero for 001, and 0 otherwise; next state FETCH.
REQ-014 SHALL decode ALUControl by funct3 in EXECUTER/EXECUTEI:
- 000: sub 0001 if op[5]&funct7b5, else add 0000
- 001: sll 0110
- 010: slt 0101
- 100: xor 0100
- 101: sra 1000 if funct7b5, else srl 0111
- 110: or 0011
- 111: and 0010
- 011: 0000
REQ-015 In JAL, SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next state ALUWB (rd ← PC+4).
REQ-016 Latency in cycles with MemReady tied 1: R/I-type 4, lw 5, sw 4, branch 3, jal 4, illegal 2; each cycle MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
REQ-017 SHALL assert at most one of PCWrite/IRWrite pair, RegWrite, MemWrite per cycle, except the PCWrite+IRWrite pair in FETCH.

Reset
REQ-018 While reset=1, state SHALL be FETCH and PCWrite, IRWrite, RegWrite, MemWrite and Illegal SHALL be 0, independent of MemReady.
REQ-019 Reset asserted in any state, including mid-MEMWRITE, SHALL force FETCH asynchronously; the first fetch SHALL occur on the first edge after release with MemReady=1.

Verification
REQ-020 add (op=0110011, funct3=000, funct7b5=0) with MemReady=1 → states 0,1,6,8,0; RegWrite=1 only in state 8; ALUControl=0000 in state 6.
REQ-021 lw with MemReady low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0; AdrSrc=1 in state 3; RegWrite with ResultSrc=01 in state 4.
REQ-022 beq with Zero=1 then with Zero=0 → PCWrite=1 in BRANCH in the first case and 0 in the second; ALUControl=0001 in both.
REQ-023 op=0110111 → DECODE then FETCH; Illegal=1 for exactly one cycle; no write enables asserted.
REQ-024 srai (op=0010011, funct3=101, funct7b5=1) → ALUControl=1000; subi-like addi with funct7b5=1 → 0000.
REQ-025 reset asserted during MEMWRITE with MemReady=0 → state=0 and MemWrite=0 immediately, without waiting for a clock edge.
